// File: rtl/key_conditioner.sv
// key_conditioner
// Per-key conditioning of raw push-button inputs: polarity normalisation,
// two-flop synchronisation, debounce, and a small per-channel state machine
// that produces single-cycle press, release and hold-to-repeat pulses.
// Every channel is an independent copy of the same slice; channels share
// only the clock and reset.
//
// There is no valid/ready handshake on this block. Pulse outputs are
// fire-and-forget strobes: each is high for exactly one clock cycle per
// event, and the consumer must sample every cycle.
//
// state_dbg exposes each channel's state register (2 bits per channel,
// channel i at [2*i +: 2]) so that external checkers can observe the FSM.

module key_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 500000,
    parameter int REPEAT_CYCLES   = 100000,
    parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_KEYS-1:0]   key_raw,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic [NUM_KEYS-1:0]   press_pulse,
    output logic [NUM_KEYS-1:0]   release_pulse,
    output logic [NUM_KEYS-1:0]   repeat_pulse,
    output logic [NUM_KEYS-1:0]   action_pulse,
    output logic [2*NUM_KEYS-1:0] state_dbg
);

    // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    // One counter serves both the initial hold delay and the repeat period.
    localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HR_W   = $clog2(HR_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HR_W-1:0] HOLD_LAST   = HR_W'(HOLD_CYCLES - 1);
    localparam logic [HR_W-1:0] REPEAT_LAST = HR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_HOLD   = 2'd1,
        ST_PRESS_REPEAT = 2'd2
    } chan_state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan

        // ---------------------------------------------------------------
        // Input side: normalise to 1 = pressed, then synchronise.
        // ---------------------------------------------------------------
        logic raw_norm;
        logic sync1_q;
        logic sync2_q;

        assign raw_norm = KEY_ACTIVE_LOW ? ~key_raw[i] : key_raw[i];

        // Two-flop synchroniser; cleared to the released level.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= raw_norm;
                sync2_q <= sync1_q;
            end
        end

        // ---------------------------------------------------------------
        // Debounce: accept a new level only after DEBOUNCE_CYCLES
        // consecutive synchronised samples disagree with the current one.
        // ---------------------------------------------------------------
        logic            level_q;
        logic            level_d;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            level_rise;
        logic            level_fall;

        // Next debounced level and run counter; any agreeing sample restarts the run.
        always_comb begin
            level_d  = level_q;
            db_cnt_d = '0;
            if (sync2_q != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Debounced level and run counter registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                level_q  <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                level_q  <= level_d;
                db_cnt_q <= db_cnt_d;
            end
        end

        // Edges are taken from the next level so the pulses register on the
        // same clock edge that the level itself changes.
        assign level_rise = level_d & ~level_q;
        assign level_fall = ~level_d & level_q;

        // ---------------------------------------------------------------
        // Channel state machine with the shared hold/repeat counter.
        // ---------------------------------------------------------------
        chan_state_t     state_q;
        chan_state_t     state_d;
        logic [HR_W-1:0] hr_cnt_q;
        logic [HR_W-1:0] hr_cnt_d;
        logic            repeat_fire;

        // State register and hold/repeat counter.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= ST_RELEASED;
                hr_cnt_q <= '0;
            end else begin
                state_q  <= state_d;
                hr_cnt_q <= hr_cnt_d;
            end
        end

        // Next state, counter and repeat strobe; a falling level always wins
        // over a repeat that happens to be due on the same edge.
        always_comb begin
            state_d     = state_q;
            hr_cnt_d    = hr_cnt_q;
            repeat_fire = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    hr_cnt_d = '0;
                    if (level_rise) begin
                        state_d = ST_PRESS_HOLD;
                    end
                end
                ST_PRESS_HOLD: begin
                    if (level_fall) begin
                        state_d  = ST_RELEASED;
                        hr_cnt_d = '0;
                    end else if (hr_cnt_q == HOLD_LAST) begin
                        state_d     = ST_PRESS_REPEAT;
                        hr_cnt_d    = '0;
                        repeat_fire = 1'b1;
                    end else begin
                        hr_cnt_d = hr_cnt_q + 1'b1;
                    end
                end
                ST_PRESS_REPEAT: begin
                    if (level_fall) begin
                        state_d  = ST_RELEASED;
                        hr_cnt_d = '0;
                    end else if (hr_cnt_q == REPEAT_LAST) begin
                        hr_cnt_d    = '0;
                        repeat_fire = 1'b1;
                    end else begin
                        hr_cnt_d = hr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_RELEASED;
                    hr_cnt_d = '0;
                end
            endcase
        end

        // ---------------------------------------------------------------
        // Registered pulse outputs.
        // ---------------------------------------------------------------
        logic press_q;
        logic release_q;
        logic repeat_q;
        logic action_q;

        // One-cycle strobes registered on the event edge.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                action_q  <= 1'b0;
            end else begin
                press_q   <= level_rise;
                release_q <= level_fall;
                repeat_q  <= repeat_fire;
                action_q  <= level_rise | repeat_fire;
            end
        end

        assign key_level[i]         = level_q;
        assign press_pulse[i]       = press_q;
        assign release_pulse[i]     = release_q;
        assign repeat_pulse[i]      = repeat_q;
        assign action_pulse[i]      = action_q;
        assign state_dbg[2*i +: 2]  = state_q;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Per-key input conditioning stage between the board push-buttons and the alarm-clock controller. It synchronises raw key inputs, debounces them, and emits single-cycle press, release and auto-repeat pulses. Key 0's `press_pulse` drives the mode state machine's `switch_signal`. The remaining keys' `action_pulse` outputs drive the time/alarm digit-increment logic, where hold-to-repeat is required.

## Interface
- NUM_KEYS, 3, number of independent key channels (≥1)
- DEBOUNCE_CYCLES, 20000, consecutive stable synchronised samples needed to accept a level change (≥1)
- HOLD_CYCLES, 500000, cycles of accepted press before the first repeat pulse (≥1)
- REPEAT_CYCLES, 100000, cycles between subsequent repeat pulses (≥1)
- KEY_ACTIVE_LOW, 0, 1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
- clock  input  1  system clock, single clock domain
- reset_n  input  1  asynchronous, active-low reset
- key_raw  input  NUM_KEYS  asynchronous raw key pins
- key_level  output  NUM_KEYS  debounced level, 1 = pressed
- press_pulse  output  NUM_KEYS  one-cycle pulse on accepted press
- release_pulse  output  NUM_KEYS  one-cycle pulse on accepted release
- repeat_pulse  output  NUM_KEYS  one-cycle pulse per auto-repeat while held
- action_pulse  output  NUM_KEYS  press_pulse | repeat_pulse, registered

## Operation
- Each channel is fully independent; all behaviour below is per bit.
- Polarity: the raw input is normalised so that 1 = pressed before synchronisation.
- Synchroniser: 2 flip-flops. Reset value is 0 (released).
- Debounce: counter width $clog2(DEBOUNCE_CYCLES+1).
  - On each edge where the synchronised value s ≠ key_level: if cnt == DEBOUNCE_CYCLES-1, then key_level <= s and cnt <= 0; otherwise cnt <= cnt+1.
  - On any edge where s == key_level: cnt <= 0.
- Channel state machine:
  - RELEASED → PRESS_HOLD when key_level rises.
  - PRESS_HOLD → PRESS_REPEAT when the hold counter reaches HOLD_CYCLES.
  - PRESS_HOLD or PRESS_REPEAT → RELEASED when key_level falls.
  - Any unused encoding → RELEASED.
- Hold/repeat counter: width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1). Cleared on entering PRESS_HOLD; reloaded to 0 on each repeat pulse.
- All pulse outputs are registered and high for exactly one cycle per event.
- Release has priority: if the release edge coincides with a due repeat, only release_pulse fires.
- Reset values:
  - All outputs 0.
  - All counters 0.
  - Synchronisers 0.
  - All channels in RELEASED.

## Timing
- Let edge k be the first clock edge at which sync stage 1 samples the new raw level, with the level stable afterwards.
- key_level changes at edge k+DEBOUNCE_CYCLES+1.
- press_pulse / release_pulse are registered at that same edge: high for the following cycle, low after the next edge.
- Let E be the press edge.
  - First repeat_pulse is registered at edge E+HOLD_CYCLES.
  - Subsequent repeats are at E+HOLD_CYCLES+n·REPEAT_CYCLES, n ≥ 1.
- action_pulse is coincident with press_pulse / repeat_pulse (same edge, not delayed).
- Raw glitches: any mismatch run of s shorter than DEBOUNCE_CYCLES samples produces no output change and restarts the count.
- Reset asserted mid-press:
  - All outputs clear asynchronously, with no release_pulse.
  - After reset deasserts, a still-held key is treated as a new press: press_pulse fires at k+DEBOUNCE_CYCLES+1 counted from the first post-reset edge.
- Simultaneous presses on different keys each produce their own pulses in the same cycle.

## Test plan
Bench parameters: NUM_KEYS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, KEY_ACTIVE_LOW=0.

1. Reset: key_raw=2'b00, reset_n low then high → all outputs 0. key_raw[0] set to 1 before edge k → key_level[0] rises at k+5, press_pulse[0]=1 for exactly one cycle, key_level[1] and all key-1 pulses stay 0.
2. Bounce rejection: key_raw[0] toggles 1,0,1,0 on consecutive cycles, then stays 0 → no output change.
3. Chatter before settle: pulses of 3 cycles high / 1 cycle low, then steady high → exactly one press_pulse, at 5 edges after the steady level is first sampled.
4. Hold-repeat: hold key 0 for 25 cycles after press edge E:
   - repeat_pulse at E+10, E+13, E+16, E+19, E+22.
   - action_pulse high at E (press) and at each of those edges.
   - On release: release_pulse once, no further repeats.
5. Release collides with a due repeat (release edge = E+13) → release_pulse only, repeat_pulse stays 0.
6. Reset mid-press: hold key 1, assert reset_n low at E+6:
   - Outputs go 0 immediately, with no release_pulse.
   - After deassert with the key still held, press_pulse[1] fires 5 edges after the first post-reset sample.
